// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one 7-seg driver; accept->o_drv_valid in 1 cycle, data held until i_drv_ready.
// Requesters are stalled (o_req_ready=0) from accept until the driver finishes its shift-out plus the hold time.
module display_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_REQ     = 3,
  parameter int HOLD_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_2s_comp,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_drv_data,
  output logic                          o_drv_2s_comp,
  output logic                          o_drv_valid,
  input  logic                          i_drv_ready,
  input  logic                          i_drv_done,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_idx,
  output logic                          o_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_START, WAIT_DONE, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_found;
  logic [DATA_WIDTH-1:0]  win_data;
  logic                   win_2s;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   accept;

  // Two passes: indices at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!win_found && (j >= int'(ptr)) && i_req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!win_found && i_req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    win_data = '0;
    win_2s   = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (IDX_W'(j) == win_idx) begin
        win_data = i_req_data[j*DATA_WIDTH +: DATA_WIDTH];
        win_2s   = i_req_2s_comp[j];
      end
    end
  end

  assign accept = (state == IDLE) && win_found;

  // Gated by rst_n so ready drops the instant reset asserts, even with valids pending.
  always_comb begin
    o_req_ready = '0;
    if (accept && rst_n) o_req_ready = NUM_REQ'(1) << win_idx;
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:       if (accept) state_nxt = SEND;
      SEND:       if (o_drv_valid && i_drv_ready) state_nxt = WAIT_START;
      WAIT_START: if (!i_drv_done) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (i_drv_done) begin
          if (HOLD_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_INIT;
          end
        end
      end
      HOLD: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_drv_data    <= '0;
      o_drv_2s_comp <= 1'b0;
      o_drv_valid   <= 1'b0;
      o_grant_idx   <= '0;
      ptr           <= '0;
    end else if (accept) begin
      o_drv_data    <= win_data;
      o_drv_2s_comp <= win_2s;
      o_drv_valid   <= 1'b1;
      o_grant_idx   <= win_idx;
      ptr           <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (o_drv_valid && i_drv_ready) begin
      o_drv_valid   <= 1'b0;
    end
  end

endmodule
